// File: rtl/alu_operand_regs.sv
// Left/right ALU operand registers. Each register loads from the shared data bus,
// and either one can drive its contents back onto that bus through a tri-state buffer.
module alu_operand_regs #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rstn,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             load_ln,
    input  logic             load_rn,
    input  logic             outn,
    input  logic             out_sel,
    output logic [WIDTH-1:0] arg_l,
    output logic [WIDTH-1:0] arg_r
);

    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] drive_data;
    logic             drive_en;

    // Both registers sample the resolved bus value. During a cross-transfer, that
    // value is the other register's old contents.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reg_a <= RESET_VALUE;
            reg_b <= RESET_VALUE;
        end else begin
            if (!load_ln) reg_a <= bus;
            if (!load_rn) reg_b <= bus;
        end
    end

    // While in reset, the buffer stays off no matter what outn says.
    assign drive_en   = !outn && rstn;
    assign drive_data = out_sel ? reg_b : reg_a;
    assign bus        = drive_en ? drive_data : {WIDTH{1'bz}};

    assign arg_l = reg_a;
    assign arg_r = reg_b;

endmodule

// File: tb/tb_alu_operand_regs.sv
// Bench for alu_operand_regs. Weak pull-ups on the bus make an undriven bus read
// as all ones, so the register values used here avoid 8'hFF wherever a Z is expected.
module tb_alu_operand_regs;

    localparam int W = 8;
    localparam logic [W-1:0] RST_VAL = 8'h00;
    localparam logic [W-1:0] BUS_Z   = 8'hFF;

    logic         clk;
    logic         rstn;
    wire  [W-1:0] bus;
    logic         load_ln;
    logic         load_rn;
    logic         outn;
    logic         out_sel;
    logic [W-1:0] arg_l;
    logic [W-1:0] arg_r;

    logic         tb_drv_en;
    logic [W-1:0] tb_drv;

    int checks;
    int errors;

    // Abstract model: two variables holding the A and B contents.
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic [2*W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus = tb_drv_en ? tb_drv : {W{1'bz}};

    for (genvar i = 0; i < W; i++) begin : g_pu
        pullup (bus[i]);
    end

    alu_operand_regs #(.WIDTH(W), .RESET_VALUE(RST_VAL)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .load_ln (load_ln),
        .load_rn (load_rn),
        .outn    (outn),
        .out_sel (out_sel),
        .arg_l   (arg_l),
        .arg_r   (arg_r)
    );

    // ---------------- driver tasks ----------------
    task automatic set_ctrl(input logic ln, input logic rn, input logic on,
                            input logic sel, input logic den, input logic [W-1:0] d);
        load_ln   = ln;
        load_rn   = rn;
        outn      = on;
        out_sel   = sel;
        tb_drv_en = den;
        tb_drv    = d;
    endtask

    // Apply controls at the falling edge, then let one rising edge pass and advance
    // the model. The data a load captures is either the register the DUT puts on the
    // bus or the value the bench drives.
    task automatic cycle(input logic ln, input logic rn, input logic on,
                         input logic sel, input logic den, input logic [W-1:0] d);
        logic [W-1:0] src;
        @(negedge clk);
        set_ctrl(ln, rn, on, sel, den, d);
        @(posedge clk);
        checks++;
        if ((!on && den) || ((!ln || !rn) && on && !den)) begin
            errors++;
            $display("FAIL stimulus: contention or load from undriven bus (outn=%b tb_drv_en=%b)", on, den);
        end
        if (rstn) begin
            src = on ? d : (sel ? m_b : m_a);
            if (!ln) m_a = src;
            if (!rn) m_b = src;
        end
        #1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        m_a = RST_VAL;
        m_b = RST_VAL;
        checks++;
        if (arg_l !== RST_VAL || arg_r !== RST_VAL) begin
            errors++;
            $display("FAIL reset_values: arg_l=%h arg_r=%h want %h", arg_l, arg_r, RST_VAL);
        end
        checks++;
        if (bus !== BUS_Z) begin
            errors++;
            $display("FAIL reset_bus_off: bus=%h want %h (undriven)", bus, BUS_Z);
        end
        @(negedge clk);
        rstn = 1'b1;
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);

        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A);
        checks++;
        if (arg_l !== 8'h5A) begin
            errors++;
            $display("FAIL load_before_reset: arg_l=%h want 5a", arg_l);
        end

        // Drop reset between edges, with a load pending and outn low.
        @(negedge clk);
        #2;
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        rstn = 1'b0;
        #1;
        m_a = RST_VAL;
        m_b = RST_VAL;
        checks++;
        if (arg_l !== RST_VAL || arg_r !== RST_VAL) begin
            errors++;
            $display("FAIL async_reset: arg_l=%h arg_r=%h want %h", arg_l, arg_r, RST_VAL);
        end
        checks++;
        if (bus !== BUS_Z) begin
            errors++;
            $display("FAIL reset_overrides_outn: bus=%h want %h", bus, BUS_Z);
        end

        // A rising edge while still in reset must not complete a load.
        set_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
        @(posedge clk);
        #1;
        checks++;
        if (arg_l !== RST_VAL || arg_r !== RST_VAL) begin
            errors++;
            $display("FAIL load_in_reset: arg_l=%h arg_r=%h want %h", arg_l, arg_r, RST_VAL);
        end
        @(negedge clk);
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        rstn = 1'b1;
    endtask

    task automatic test_independent_loads();
        @(negedge clk);
        set_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C);
        #1;
        checks++;
        if (arg_l !== RST_VAL) begin
            errors++;
            $display("FAIL load_l_early: arg_l=%h want %h before edge", arg_l, RST_VAL);
        end
        @(posedge clk);
        #1;
        m_a = 8'h3C;
        checks++;
        if (arg_l !== 8'h3C || arg_r !== RST_VAL) begin
            errors++;
            $display("FAIL load_l: arg_l=%h arg_r=%h want 3c %h", arg_l, arg_r, RST_VAL);
        end
        @(negedge clk);
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC3);
        #1;
        checks++;
        if (arg_r !== RST_VAL) begin
            errors++;
            $display("FAIL load_r_early: arg_r=%h want %h before edge", arg_r, RST_VAL);
        end
        @(posedge clk);
        #1;
        m_b = 8'hC3;
        checks++;
        if (arg_l !== 8'h3C || arg_r !== 8'hC3) begin
            errors++;
            $display("FAIL load_r: arg_l=%h arg_r=%h want 3c c3", arg_l, arg_r);
        end
    endtask

    task automatic test_dual_load();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
        checks++;
        if (arg_l !== 8'hFF || arg_r !== 8'hFF) begin
            errors++;
            $display("FAIL dual_load: arg_l=%h arg_r=%h want ff ff", arg_l, arg_r);
        end
    endtask

    task automatic test_bus_drive();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h34);
        @(negedge clk);
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #1;
        checks++;
        if (bus !== 8'h12) begin
            errors++;
            $display("FAIL drive_a: bus=%h want 12", bus);
        end
        out_sel = 1'b1;
        #1;
        checks++;
        if (bus !== 8'h34) begin
            errors++;
            $display("FAIL drive_b: bus=%h want 34", bus);
        end
        outn = 1'b1;
        #1;
        checks++;
        if (bus !== BUS_Z) begin
            errors++;
            $display("FAIL drive_off: bus=%h want %h", bus, BUS_Z);
        end
    endtask

    task automatic test_cross_transfer();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (arg_r !== 8'hA5 || arg_l !== 8'hA5) begin
            errors++;
            $display("FAIL cross_a_to_b: arg_l=%h arg_r=%h want a5 a5", arg_l, arg_r);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (arg_l !== 8'hA5 || arg_r !== 8'hA5) begin
            errors++;
            $display("FAIL cross_b_to_a: arg_l=%h arg_r=%h want a5 a5", arg_l, arg_r);
        end
    endtask

    task automatic test_self_load_hold();
        logic [W-1:0] b_before;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77);
        b_before = m_b;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            checks++;
            if (arg_l !== 8'h77) begin
                errors++;
                $display("FAIL self_load[%0d]: arg_l=%h want 77", i, arg_l);
            end
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11);
            checks++;
            if (arg_l !== 8'h77 || arg_r !== b_before) begin
                errors++;
                $display("FAIL hold[%0d]: arg_l=%h arg_r=%h want 77 %h", i, arg_l, arg_r, b_before);
            end
        end
    endtask

    task automatic test_random();
        logic         ln, rn, on, sel;
        logic [W-1:0] d;
        logic [2*W-1:0] got, want;
        for (int i = 0; i < 200; i++) begin
            ln  = 1'($urandom_range(0, 1));
            rn  = 1'($urandom_range(0, 1));
            on  = 1'($urandom_range(0, 1));
            sel = 1'($urandom_range(0, 1));
            d   = W'($urandom_range(0, 255));
            if (!on) begin
                @(negedge clk);
                set_ctrl(1'b1, 1'b1, 1'b0, sel, 1'b0, '0);
                #1;
                checks++;
                if (bus !== (sel ? m_b : m_a)) begin
                    errors++;
                    $display("FAIL rand_bus[%0d]: bus=%h want %h", i, bus, sel ? m_b : m_a);
                end
            end
            cycle(ln, rn, on, sel, on, d);
            exp_q.push_back({m_a, m_b});
            got  = {arg_l, arg_r};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rand_regs[%0d]: a/b=%h want %h", i, got, want);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        m_a    = RST_VAL;
        m_b    = RST_VAL;
        test_reset();
        test_independent_loads();
        test_dual_load();
        test_bus_drive();
        test_cross_transfer();
        test_self_load_hold();
        test_random();
        go_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
